// File: rtl/ece429_decode_stage.sv
// ece429_decode_stage: MIPS decode stage with 2-entry skid buffering.
// Registers a fully decoded bundle; flushable; keeps decode statistics.
module ece429_decode_stage #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [0:31]       insn_in,
    input  logic [ADDR_W-1:0] pc_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [5:0]        op_out,
    output logic [4:0]        rs_out,
    output logic [4:0]        rt_out,
    output logic [4:0]        rd_out,
    output logic [4:0]        shamt_out,
    output logic [DATA_W-1:0] imm_out,
    output logic [ADDR_W-1:0] target_out,
    output logic [4:0]        dst_out,
    output logic              dst_valid,
    output logic              is_branch,
    output logic              is_jump,
    output logic              is_load,
    output logic              is_store,
    output logic              illegal,
    output logic [ADDR_W-1:0] pc_out,
    output logic [CNT_W-1:0]  decoded_cnt,
    output logic [CNT_W-1:0]  illegal_cnt
);
    localparam logic [5:0] OP_NOP = 6'd0, OP_SLL = 6'd1, OP_SRL = 6'd2;
    localparam logic [5:0] OP_SRA = 6'd3, OP_JR = 6'd4, OP_ADD = 6'd5;
    localparam logic [5:0] OP_ADDU = 6'd6, OP_SUB = 6'd7, OP_SUBU = 6'd8;
    localparam logic [5:0] OP_AND = 6'd9, OP_OR = 6'd10, OP_XOR = 6'd11;
    localparam logic [5:0] OP_NOR = 6'd12, OP_SLT = 6'd13, OP_SLTU = 6'd14;
    localparam logic [5:0] OP_BLTZ = 6'd15, OP_BGEZ = 6'd16, OP_J = 6'd17;
    localparam logic [5:0] OP_JAL = 6'd18, OP_BEQ = 6'd19, OP_BNE = 6'd20;
    localparam logic [5:0] OP_BLEZ = 6'd21, OP_BGTZ = 6'd22, OP_ADDIU = 6'd23;
    localparam logic [5:0] OP_SLTI = 6'd24, OP_ORI = 6'd25, OP_LUI = 6'd26;
    localparam logic [5:0] OP_MUL = 6'd27, OP_LB = 6'd28, OP_LW = 6'd29;
    localparam logic [5:0] OP_LBU = 6'd30, OP_SB = 6'd31, OP_SW = 6'd32;
    localparam logic [5:0] OP_ILL = 6'd63;

    logic [31:0]       r_skid_insn;
    logic [ADDR_W-1:0] r_skid_pc;
    logic              r_skid_full;
    logic              r_out_valid;
    logic [5:0]        r_op;
    logic [4:0]        r_rs, r_rt, r_rd, r_shamt, r_dst;
    logic [DATA_W-1:0] r_imm;
    logic [ADDR_W-1:0] r_tgt, r_pc;
    logic [CNT_W-1:0]  r_dec_cnt, r_ill_cnt;

    logic [31:0]       w_in_insn, w_insn;
    logic [ADDR_W-1:0] w_pc, w_pc4, w_jt, w_tgt;
    logic [5:0]        w_opc, w_funct, w_op;
    logic [15:0]       w_imm16;
    logic [DATA_W-1:0] w_imm;
    logic [4:0]        w_dst;
    logic              w_acc, w_drain, w_is_br;

    // Big-endian bit numbering on the port: insn_in[0] lands in w_in_insn[31].
    assign w_in_insn = insn_in;
    assign w_insn    = r_skid_full ? r_skid_insn : w_in_insn;
    assign w_pc      = r_skid_full ? r_skid_pc : pc_in;
    assign w_opc     = w_insn[31:26];
    assign w_funct   = w_insn[5:0];
    assign w_imm16   = w_insn[15:0];
    assign w_acc     = in_valid & ~r_skid_full;
    assign w_drain   = r_out_valid & out_ready;
    assign w_pc4     = w_pc + ADDR_W'(4);
    assign w_jt      = (w_pc4 & ~ADDR_W'(28'hFFF_FFFF))
                     | ADDR_W'({w_insn[25:0], 2'b00});
    assign w_is_br   = w_op inside {OP_BLTZ, OP_BGEZ, [OP_BEQ:OP_BGTZ]};

    // Opcode/funct/REGIMM decode to the op enum.
    always_comb begin
        w_op = OP_ILL;
        case (w_opc)
            6'b000000: begin
                if (w_insn == 32'd0) w_op = OP_NOP;
                else begin
                    case (w_funct)
                        6'b000000: w_op = OP_SLL;
                        6'b000010: w_op = OP_SRL;
                        6'b000011: w_op = OP_SRA;
                        6'b001000: w_op = OP_JR;
                        6'b100000: w_op = OP_ADD;
                        6'b100001: w_op = OP_ADDU;
                        6'b100010: w_op = OP_SUB;
                        6'b100011: w_op = OP_SUBU;
                        6'b100100: w_op = OP_AND;
                        6'b100101: w_op = OP_OR;
                        6'b100110: w_op = OP_XOR;
                        6'b100111: w_op = OP_NOR;
                        6'b101010: w_op = OP_SLT;
                        6'b101011: w_op = OP_SLTU;
                        default:   w_op = OP_ILL;
                    endcase
                end
            end
            6'b000001: begin
                if (w_insn[20:16] == 5'd0) w_op = OP_BLTZ;
                else if (w_insn[20:16] == 5'd1) w_op = OP_BGEZ;
            end
            6'b000010: w_op = OP_J;
            6'b000011: w_op = OP_JAL;
            6'b000100: w_op = OP_BEQ;
            6'b000101: w_op = OP_BNE;
            6'b000110: w_op = OP_BLEZ;
            6'b000111: w_op = OP_BGTZ;
            6'b001001: w_op = OP_ADDIU;
            6'b001010: w_op = OP_SLTI;
            6'b001101: w_op = OP_ORI;
            6'b001111: w_op = OP_LUI;
            6'b011100: if (w_funct == 6'b000010) w_op = OP_MUL;
            6'b100000: w_op = OP_LB;
            6'b100011: w_op = OP_LW;
            6'b100100: w_op = OP_LBU;
            6'b101000: w_op = OP_SB;
            6'b101011: w_op = OP_SW;
            default:   w_op = OP_ILL;
        endcase
    end

    // Immediate extension, control-flow target and destination selection.
    always_comb begin
        w_imm = DATA_W'($signed(w_imm16));
        if (w_op == OP_ORI) w_imm = DATA_W'(w_imm16);
        else if (w_op == OP_LUI) w_imm = DATA_W'({w_imm16, 16'h0000});
        w_tgt = '0;
        if (w_is_br) w_tgt = w_pc4 + ADDR_W'($signed({w_imm16, 2'b00}));
        else if (w_op == OP_J || w_op == OP_JAL) w_tgt = w_jt;
        w_dst = 5'd0;
        if (w_op inside {[OP_SLL:OP_SRA], [OP_ADD:OP_SLTU], OP_MUL})
            w_dst = w_insn[15:11];
        else if (w_op inside {[OP_ADDIU:OP_LUI], [OP_LB:OP_LBU]})
            w_dst = w_insn[20:16];
        else if (w_op == OP_JAL)
            w_dst = 5'd31;
    end

    // Output/skid registers: skid entry always moves to the output first.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_skid_full <= 1'b0;
            r_skid_insn <= '0;
            r_skid_pc   <= '0;
            r_op        <= '0;
            r_rs        <= '0;
            r_rt        <= '0;
            r_rd        <= '0;
            r_shamt     <= '0;
            r_dst       <= '0;
            r_imm       <= '0;
            r_tgt       <= '0;
            r_pc        <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
            r_skid_full <= 1'b0;
        end else if (!r_out_valid || out_ready) begin
            if (r_skid_full || w_acc) begin
                r_out_valid <= 1'b1;
                r_skid_full <= 1'b0;
                r_op        <= w_op;
                r_rs        <= w_insn[25:21];
                r_rt        <= w_insn[20:16];
                r_rd        <= w_insn[15:11];
                r_shamt     <= w_insn[10:6];
                r_dst       <= w_dst;
                r_imm       <= w_imm;
                r_tgt       <= w_tgt;
                r_pc        <= w_pc;
            end else begin
                r_out_valid <= 1'b0;
            end
        end else if (w_acc) begin
            r_skid_insn <= w_in_insn;
            r_skid_pc   <= pc_in;
            r_skid_full <= 1'b1;
        end
    end

    // Delivery statistics: total wraps, illegal saturates.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_dec_cnt <= '0;
            r_ill_cnt <= '0;
        end else if (w_drain) begin
            r_dec_cnt <= r_dec_cnt + CNT_W'(1);
            if (r_op == OP_ILL && !(&r_ill_cnt))
                r_ill_cnt <= r_ill_cnt + CNT_W'(1);
        end
    end

    assign in_ready    = ~r_skid_full;
    assign out_valid   = r_out_valid;
    assign op_out      = r_op;
    assign rs_out      = r_rs;
    assign rt_out      = r_rt;
    assign rd_out      = r_rd;
    assign shamt_out   = r_shamt;
    assign imm_out     = r_imm;
    assign target_out  = r_tgt;
    assign dst_out     = r_dst;
    assign dst_valid   = (r_dst != 5'd0);
    assign is_branch   = r_op inside {OP_BLTZ, OP_BGEZ, [OP_BEQ:OP_BGTZ]};
    assign is_jump     = r_op inside {OP_J, OP_JAL, OP_JR};
    assign is_load     = r_op inside {[OP_LB:OP_LBU]};
    assign is_store    = r_op inside {OP_SB, OP_SW};
    assign illegal     = (r_op == OP_ILL);
    assign pc_out      = r_pc;
    assign decoded_cnt = r_dec_cnt;
    assign illegal_cnt = r_ill_cnt;
endmodule

// File: tb/tb_ece429_decode_stage.sv
// tb_ece429_decode_stage: directed checks of decode, targets,
// backpressure, flush, counters and asynchronous reset.
module tb_ece429_decode_stage;
    logic        clock = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [31:0] insn_in, pc_in;
    logic        in_ready, out_valid, dst_valid;
    logic        is_branch, is_jump, is_load, is_store, illegal;
    logic [5:0]  op_out;
    logic [4:0]  rs_out, rt_out, rd_out, shamt_out, dst_out;
    logic [31:0] imm_out, target_out, pc_out;
    logic [2:0]  decoded_cnt, illegal_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int exp_dec  = 0;

    ece429_decode_stage #(.ADDR_W(32), .DATA_W(32), .CNT_W(3)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .insn_in(insn_in), .pc_in(pc_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .op_out(op_out), .rs_out(rs_out), .rt_out(rt_out),
        .rd_out(rd_out), .shamt_out(shamt_out), .imm_out(imm_out),
        .target_out(target_out), .dst_out(dst_out),
        .dst_valid(dst_valid), .is_branch(is_branch),
        .is_jump(is_jump), .is_load(is_load), .is_store(is_store),
        .illegal(illegal), .pc_out(pc_out),
        .decoded_cnt(decoded_cnt), .illegal_cnt(illegal_cnt)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send1(input logic [31:0] insn, input logic [31:0] pc);
        in_valid = 1'b1;
        insn_in  = insn;
        pc_in    = pc;
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        exp_dec++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            @(negedge clock);
        end
    endtask

    logic [31:0] bp_insn [4];
    logic [31:0] bp_pc   [4];
    logic [5:0]  bp_op   [4];
    int          accepted, got, cyc;
    logic        acc;

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        insn_in = '0; pc_in = '0;
        idle(2);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_op", op_out, 0);
        check("rst_imm", imm_out, 0);
        check("rst_dec_cnt", decoded_cnt, 0);
        check("rst_ill_cnt", illegal_cnt, 0);
        reset = 1'b0;
        idle(1);

        send1(32'h012A4020, 32'h0040_0000);
        check("add_valid", out_valid, 1);
        check("add_op", op_out, 5);
        check("add_rd", rd_out, 8);
        check("add_rs", rs_out, 9);
        check("add_rt", rt_out, 10);
        check("add_dst", dst_out, 8);
        check("add_dstv", dst_valid, 1);
        check("add_pc", pc_out, 32'h0040_0000);
        check("add_tgt", target_out, 0);
        send1(32'h3C011001, 32'h0040_0004);
        check("lui_op", op_out, 26);
        check("lui_imm", imm_out, 32'h1001_0000);
        check("lui_dst", dst_out, 1);
        send1(32'h1109FFFF, 32'h0040_0010);
        check("beq_op", op_out, 19);
        check("beq_tgt", target_out, 32'h0040_0010);
        check("beq_br", is_branch, 1);
        check("beq_dstv", dst_valid, 0);
        send1(32'h0C100008, 32'h0040_0020);
        check("jal_op", op_out, 18);
        check("jal_tgt", target_out, 32'h0040_0020);
        check("jal_dst", dst_out, 31);
        check("jal_jump", is_jump, 1);
        send1(32'h1C200003, 32'h0040_0030);
        check("bgtz_op", op_out, 22);
        check("bgtz_tgt", target_out, 32'h0040_0040);
        send1(32'h3421FFFF, 32'h0);
        check("ori_op", op_out, 25);
        check("ori_imm", imm_out, 32'h0000_FFFF);
        send1(32'h2402FFFF, 32'h0);
        check("addiu_op", op_out, 23);
        check("addiu_imm", imm_out, 32'hFFFF_FFFF);
        check("addiu_dst", dst_out, 2);
        send1(32'h8C430004, 32'h0);
        check("lw_op", op_out, 29);
        check("lw_load", is_load, 1);
        check("lw_dst", dst_out, 3);
        send1(32'hAC430004, 32'h0);
        check("sw_op", op_out, 32);
        check("sw_store", is_store, 1);
        check("sw_dstv", dst_valid, 0);
        send1(32'h08000001, 32'h3FFF_FFFC);
        check("j_op", op_out, 17);
        check("j_tgt", target_out, 32'h4000_0004);
        send1(32'h70431002, 32'h0);
        check("mul_op", op_out, 27);
        check("mul_dst", dst_out, 2);
        send1(32'h0000_0000, 32'h0);
        check("nop_op", op_out, 0);
        check("nop_dstv", dst_valid, 0);
        send1(32'h00021080, 32'h0);
        check("sll_op", op_out, 1);
        check("sll_shamt", shamt_out, 2);
        check("sll_dstv", dst_valid, 1);
        send1(32'h0440FFFE, 32'h0000_0100);
        check("bltz_op", op_out, 15);
        check("bltz_tgt", target_out, 32'h0000_00FC);
        send1(32'h1400FFFD, 32'h0);
        check("bne_op", op_out, 20);
        check("bne_wrap", target_out, 32'hFFFF_FFF8);
        idle(1);
        check("sweep_dec_cnt", decoded_cnt, 64'(exp_dec & 7));
        check("sweep_ill_cnt", illegal_cnt, 0);

        send1(32'hFC00_0000, 32'h0);
        check("ill_op_fc", op_out, 63);
        check("ill_flag_fc", illegal, 1);
        send1(32'h0000_003F, 32'h0);
        check("ill_op_f3f", op_out, 63);
        send1(32'h0442_0000, 32'h0);
        check("ill_regimm", op_out, 63);
        check("ill_cnt_2", illegal_cnt, 2);
        send1(32'h7000_0000, 32'h0);
        check("ill_special2", op_out, 63);
        send1(32'h2000_0000, 32'h0);
        send1(32'hFC00_0000, 32'h0);
        send1(32'h0000_003F, 32'h0);
        idle(1);
        check("ill_cnt_max", illegal_cnt, 7);
        send1(32'hFC00_0000, 32'h0);
        idle(1);
        check("ill_cnt_sat", illegal_cnt, 7);
        check("ill_dec_cnt", decoded_cnt, 64'(exp_dec & 7));

        bp_insn[0] = 32'h012A4020; bp_pc[0] = 32'h1000; bp_op[0] = 5;
        bp_insn[1] = 32'h8C430004; bp_pc[1] = 32'h1004; bp_op[1] = 29;
        bp_insn[2] = 32'h3C011001; bp_pc[2] = 32'h1008; bp_op[2] = 26;
        bp_insn[3] = 32'hAC430004; bp_pc[3] = 32'h100C; bp_op[3] = 32;
        out_ready = 1'b0;
        accepted = 0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            insn_in  = bp_insn[accepted];
            pc_in    = bp_pc[accepted];
            acc      = in_ready;
            @(posedge clock);
            @(negedge clock);
            if (acc) accepted++;
        end
        check("bp_accepted", accepted, 2);
        check("bp_in_ready", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
        check("bp_head_pc", pc_out, 32'h1000);
        out_ready = 1'b1;
        got = 0;
        cyc = 0;
        while (got < 4 && cyc < 30) begin
            if (accepted < 4) begin
                in_valid = 1'b1;
                insn_in  = bp_insn[accepted];
                pc_in    = bp_pc[accepted];
            end else begin
                in_valid = 1'b0;
            end
            acc = in_valid && in_ready;
            if (out_valid) begin
                check($sformatf("bp_pc%0d", got), pc_out, bp_pc[got]);
                check($sformatf("bp_op%0d", got), op_out, bp_op[got]);
                got++;
            end
            @(posedge clock);
            @(negedge clock);
            if (acc) accepted++;
            cyc++;
        end
        in_valid = 1'b0;
        exp_dec += 4;
        check("bp_got", got, 4);
        check("bp_drained", out_valid, 0);
        check("bp_dec_cnt", decoded_cnt, 64'(exp_dec & 7));

        out_ready = 1'b0;
        in_valid = 1'b1; insn_in = 32'h012A4020; pc_in = 32'h2000;
        idle(1);
        in_valid = 1'b1; insn_in = 32'h3C011001; pc_in = 32'h2004;
        idle(1);
        check("fl_held_ir", in_ready, 0);
        flush = 1'b1;
        in_valid = 1'b1; insn_in = 32'h8C430004; pc_in = 32'h2008;
        idle(1);
        flush = 1'b0; in_valid = 1'b0;
        check("fl_out_valid", out_valid, 0);
        check("fl_in_ready", in_ready, 1);
        out_ready = 1'b1;
        idle(1);
        check("fl_absent", out_valid, 0);
        out_ready = 1'b0;
        in_valid = 1'b1; insn_in = 32'h012A4020; pc_in = 32'h3000;
        idle(1);
        flush = 1'b1;
        in_valid = 1'b1; insn_in = 32'h2402FFFF; pc_in = 32'h3004;
        idle(1);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        check("fl2_out_valid", out_valid, 0);
        idle(1);
        check("fl2_absent", out_valid, 0);
        check("fl_dec_cnt", decoded_cnt, 64'(exp_dec & 7));

        out_ready = 1'b0;
        in_valid = 1'b1; insn_in = 32'hFC00_0000; pc_in = 32'h4000;
        idle(1);
        in_valid = 1'b0;
        check("ar_pre_valid", out_valid, 1);
        #2 reset = 1'b1;
        #1;
        check("ar_out_valid", out_valid, 0);
        check("ar_dec_cnt", decoded_cnt, 0);
        check("ar_ill_cnt", illegal_cnt, 0);
        check("ar_in_ready", in_ready, 1);
        check("ar_op", op_out, 0);
        @(negedge clock);
        reset = 1'b0;
        out_ready = 1'b1;
        send1(32'h012A4020, 32'h5000);
        check("ar_resume_op", op_out, 5);
        check("ar_resume_pc", pc_out, 32'h5000);
        idle(1);
        check("ar_resume_cnt", decoded_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/ece429_decode_stage.md
Name: ece429_decode_stage

Overview:
- Clocked, parametrised MIPS decode stage between fetch and register-read/execute.
- Accepts {insn, pc} over a valid/ready handshake; registers a fully decoded bundle (op enum, register fields, extended immediate, branch/jump targets, destination, class flags).
- Uses a 2-entry skid buffer for full throughput under backpressure; supports pipeline flush and keeps decode statistics.

Parameters:
- ADDR_W, 32, width of pc_in and target outputs (min 28).
- DATA_W, 32, width of imm_out (min 32).
- CNT_W, 16, width of statistics counters.

Ports:
- clock  in  1  stage clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous; discards all held entries.
- in_valid  in  1  insn_in/pc_in valid.
- in_ready  out  1  stage can accept.
- insn_in  in  32  instruction word; bit 0 = MSB.
- pc_in  in  ADDR_W  address of insn_in.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  consumer accepts bundle.
- op_out  out  6  decoded op enum.
- rs_out, rt_out, rd_out, shamt_out  out  5 each  raw fields.
- imm_out  out  DATA_W  extended immediate.
- target_out  out  ADDR_W  branch/jump target.
- dst_out  out  5  destination register.
- dst_valid  out  1  op writes a register.
- is_branch, is_jump, is_load, is_store  out  1 each  class flags.
- illegal  out  1  op_out == 63.
- pc_out  out  ADDR_W  pc of the bundle.
- decoded_cnt  out  CNT_W  bundles delivered.
- illegal_cnt  out  CNT_W  illegal bundles delivered.

Behaviour:
- Op enum:
  - 0 NOP (insn == 0)
  - 1 SLL, 2 SRL, 3 SRA, 4 JR
  - 5 ADD, 6 ADDU, 7 SUB, 8 SUBU, 9 AND, 10 OR, 11 XOR, 12 NOR, 13 SLT, 14 SLTU
  - 15 BLTZ, 16 BGEZ, 17 J, 18 JAL, 19 BEQ, 20 BNE, 21 BLEZ (opcode 000110), 22 BGTZ (opcode 000111)
  - 23 ADDIU, 24 SLTI, 25 ORI, 26 LUI, 27 MUL (SPECIAL2 funct 000010)
  - 28 LB, 29 LW, 30 LBU, 31 SB, 32 SW
  - 63 any other opcode, funct or REGIMM rt.
- Immediate:
  - Sign-extended to DATA_W by default.
  - ORI: zero-extended.
  - LUI: {imm16, 16'b0}, zero-extended above bit 31.
- Targets (ADDR_W arithmetic, wrap mod 2^ADDR_W):
  - Branches: pc+4 + sext(imm16<<2).
  - J/JAL: {(pc+4)[top 4 bits], insn[6:31], 2'b00}.
  - All others: 0.
- Destination:
  - R-type and MUL: rd.
  - I-type ALU and loads: rt.
  - JAL: 31.
  - All others: 0 with dst_valid = 0.
  - dst_valid = 0 whenever the destination is 0.
- Class flags:
  - is_jump: J, JAL, JR.
  - is_branch: ops 15,16,19–22.
  - is_load: 28–30.
  - is_store: 31–32.
- Pipeline:
  - Output register holds the bundle; skid register holds one extra entry.
  - Latency: 1 cycle from accepted input to out_valid.
  - in_ready = !skid_full; registered, no combinational path from out_ready.
- Handshake:
  - Transfer on valid & ready.
  - out_valid held high and bundle stable until out_ready.
  - Output empty, or draining this cycle: the accepted input loads the output register (from skid first if skid is full).
  - Output held while an input is accepted: the input goes to skid, and in_ready drops next cycle.
  - Skid and output drain in FIFO order; no reorder, no drop.
- flush: next edge clears out_valid and skid_full; any input accepted in the same cycle is discarded; counters unaffected.
- Counters:
  - decoded_cnt increments on each output transfer, wraps.
  - illegal_cnt increments on an output transfer with illegal = 1, saturates at all-ones.
- Reset (async): out_valid=0, in_ready=1, skid empty, all bundle outputs 0, both counters 0. Reset mid-transfer drops held entries.

Test Plan:
- Decode sweep: insn 0x012A4020 at pc 0x00400000, out_ready=1 -> next cycle op=5 (ADD), rd=8, rs=9, rt=10, dst=8, dst_valid=1; insn 0x3C011001 -> op=26, imm=0x10010000, dst=1.
- Targets: BEQ 0x1109FFFF at pc 0x00400010 -> target 0x00400010; JAL 0x0C100008 at pc 0x00400020 -> target 0x00400020, dst=31; BGTZ 0x1C200003 -> op=22.
- Backpressure: stream 4 instructions with out_ready=0 -> in_ready falls after 2 accepted; release out_ready -> all 4 emerge in order, no duplicates, decoded_cnt=4.
- Illegal: insn 0xFC000000 and SPECIAL funct 0x3F -> op=63, illegal=1; illegal_cnt=2; preload illegal_cnt to max-1 via 3 more -> saturates at all-ones.
- Flush: 2 entries held, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, flushed-cycle input absent.
- Async reset: assert reset mid-stream between edges -> out_valid=0 and counters=0 immediately; resume cleanly after release.
